// File: rtl/dbg_mem_loader.sv
// dbg_mem_loader: debug-side master for data-RAM port B.
//
// Parses a byte-stream command protocol arriving from the debug UART and performs multi-word
// memory writes and reads on port B. Read data and the ACK/NAK response byte go back out on the
// UART TX byte stream. o_busy tells the core to stall its port-A accesses while a frame is live.
//
// Frame: CMD(1) ADDR(4, LE byte address) CNT(2, LE word count N) [write: N*4 data bytes, LE].
//   CMD 0x57 = write, 0x52 = read, anything else is answered with NAK 0x15.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   rx_data    received byte            rx_valid / rx_ready  receive handshake
//   tx_data    byte to transmit         tx_valid / tx_ready  transmit handshake
//   web        port-B byte write enables (4'b1111 for one cycle per written word)
//   addrb      port-B word address (byte address >> 2)
//   dinb       port-B write data        doutb               port-B read data
//   o_busy     frame in progress (cmd accept cycle through final response byte)
//   o_timeout  one-cycle pulse when a frame is aborted by the inter-byte timeout
//
// Parameters:
//   RD_LAT     port-B read latency in cycles, addrb presented to doutb valid (>= 1)
//   TIMEOUT    idle cycles allowed between RX bytes inside a frame before abort (>= 2)

module dbg_mem_loader #(
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [3:0]  web,
    output logic [31:0] addrb,
    output logic [31:0] dinb,
    input  logic [31:0] doutb,
    output logic        o_busy,
    output logic        o_timeout
);

    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
    localparam int unsigned LatW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);
    localparam logic [LatW-1:0] LatLast = LatW'(RD_LAT - 1);

    localparam logic [7:0] CmdWrite = 8'h57;
    localparam logic [7:0] CmdRead  = 8'h52;
    localparam logic [7:0] RspAck   = 8'h06;
    localparam logic [7:0] RspNak   = 8'h15;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StCnt,
        StWdata,
        StWrite,
        StRreq,
        StRwait,
        StRsend,
        StDrain,
        StResp
    } state_e;

    state_e          state_q, state_d;
    logic            is_wr_q, is_wr_d;
    logic [31:0]     addr_q, addr_d;     // byte address as received
    logic [29:0]     waddr_q, waddr_d;   // word address, wraps naturally at 30 bits
    logic [15:0]     cnt_q, cnt_d;       // words remaining
    logic [1:0]      idx_q, idx_d;       // byte index within the current field/word
    logic [31:0]     word_q, word_d;     // write assembler and read shift register
    logic [7:0]      resp_q, resp_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [LatW-1:0] lat_q, lat_d;

    logic        rx_fire;
    logic        tx_fire;
    logic        rx_state;
    logic        tmo_state;
    logic        tmo_fire;
    logic [15:0] cnt_new;

    // ------------------------------------------------------------------
    // Outputs decoded from registered state. Reset gates the handshakes
    // and the write strobe so nothing escapes during the reset cycle.
    // ------------------------------------------------------------------
    assign rx_state  = (state_q inside {StIdle, StAddr, StCnt, StWdata, StDrain});
    assign tmo_state = (state_q inside {StAddr, StCnt, StWdata, StDrain});

    assign rx_ready = rx_state && !rst;
    assign rx_fire  = rx_valid && rx_ready;

    assign tx_valid = (state_q == StRsend || state_q == StResp) && !rst;
    assign tx_fire  = tx_valid && tx_ready;

    always_comb begin
        tx_data = 8'h00;
        if (state_q == StResp) begin
            tx_data = resp_q;
        end else if (state_q == StRsend) begin
            tx_data = word_q[7:0];
        end
    end

    assign web   = (state_q == StWrite && !rst) ? 4'b1111 : 4'b0000;
    assign addrb = {2'b00, waddr_q};
    assign dinb  = word_q;

    // A byte arriving on the last allowed cycle still counts; only a silent cycle expires.
    assign tmo_fire  = tmo_state && !rx_fire && (tmo_q == TmoLast);
    assign o_timeout = tmo_fire && !rst;

    // Busy covers the cmd accept cycle itself, before the state register leaves IDLE.
    assign o_busy = !rst && ((state_q != StIdle) || rx_fire);

    assign cnt_new = {rx_data, cnt_q[15:8]};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        is_wr_d = is_wr_q;
        addr_d  = addr_q;
        waddr_d = waddr_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        word_d  = word_q;
        resp_d  = resp_q;
        lat_d   = lat_q;

        if (!tmo_state || rx_fire) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TmoW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (rx_fire) begin
                    is_wr_d = (rx_data == CmdWrite);
                    idx_d   = 2'd0;
                    if (rx_data == CmdWrite || rx_data == CmdRead) begin
                        state_d = StAddr;
                    end else begin
                        resp_d  = RspNak;
                        state_d = StResp;
                    end
                end
            end

            StAddr: begin
                if (tmo_fire) begin
                    state_d = StIdle;
                end else if (rx_fire) begin
                    addr_d = {rx_data, addr_q[31:8]};
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        idx_d   = 2'd0;
                        state_d = StCnt;
                    end
                end
            end

            StCnt: begin
                if (tmo_fire) begin
                    state_d = StIdle;
                end else if (rx_fire) begin
                    cnt_d = cnt_new;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd1) begin
                        idx_d   = 2'd0;
                        waddr_d = addr_q[31:2];
                        if (addr_q[1:0] != 2'b00) begin
                            // Misaligned: a write still swallows its payload so the
                            // stream stays in frame sync.
                            if (is_wr_q && cnt_new != 16'd0) begin
                                state_d = StDrain;
                            end else begin
                                resp_d  = RspNak;
                                state_d = StResp;
                            end
                        end else if (cnt_new == 16'd0) begin
                            resp_d  = RspAck;
                            state_d = StResp;
                        end else begin
                            state_d = is_wr_q ? StWdata : StRreq;
                        end
                    end
                end
            end

            StWdata: begin
                if (tmo_fire) begin
                    state_d = StIdle;
                end else if (rx_fire) begin
                    word_d = {rx_data, word_q[31:8]};
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end

            StWrite: begin
                waddr_d = waddr_q + 30'd1;
                cnt_d   = cnt_q - 16'd1;
                idx_d   = 2'd0;
                if (cnt_q == 16'd1) begin
                    resp_d  = RspAck;
                    state_d = StResp;
                end else begin
                    state_d = StWdata;
                end
            end

            StRreq: begin
                lat_d   = '0;
                state_d = StRwait;
            end

            StRwait: begin
                if (lat_q == LatLast) begin
                    word_d  = doutb;
                    idx_d   = 2'd0;
                    state_d = StRsend;
                end else begin
                    lat_d = lat_q + LatW'(1);
                end
            end

            StRsend: begin
                if (tx_fire) begin
                    word_d = {8'h00, word_q[31:8]};
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        waddr_d = waddr_q + 30'd1;
                        cnt_d   = cnt_q - 16'd1;
                        if (cnt_q == 16'd1) begin
                            resp_d  = RspAck;
                            state_d = StResp;
                        end else begin
                            state_d = StRreq;
                        end
                    end
                end
            end

            StDrain: begin
                if (tmo_fire) begin
                    state_d = StIdle;
                end else if (rx_fire) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        cnt_d = cnt_q - 16'd1;
                        if (cnt_q == 16'd1) begin
                            resp_d  = RspNak;
                            state_d = StResp;
                        end
                    end
                end
            end

            StResp: begin
                if (tx_fire) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            waddr_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            resp_q  <= '0;
            tmo_q   <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            waddr_q <= waddr_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            resp_q  <= resp_d;
            tmo_q   <= tmo_d;
            lat_q   <= lat_d;
        end
    end

endmodule

// File: tb/tb_dbg_mem_loader.sv
// Self-checking bench for dbg_mem_loader. Two instances (read latency 1 and 3, timeout 16)
// share one stimulus driver selected by 'sel'; each has its own port-B memory model.
// Expected TX bytes and port-B writes are queued when stimulus is driven and compared
// against what the monitors collected once the frame completes.

module tb_dbg_mem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        tx_ready = 1'b1;

    logic        rx_ready_a, tx_valid_a, busy_a, tmo_a;
    logic [7:0]  tx_data_a;
    logic [3:0]  web_a;
    logic [31:0] addrb_a, dinb_a, doutb_a;

    logic        rx_ready_b, tx_valid_b, busy_b, tmo_b;
    logic [7:0]  tx_data_b;
    logic [3:0]  web_b;
    logic [31:0] addrb_b, dinb_b, doutb_b;

    logic        rx_ready, tx_valid, o_busy, o_timeout;
    logic [7:0]  tx_data;
    logic [3:0]  web;
    logic [31:0] addrb, dinb;

    int vectors = 0;
    int miscompares = 0;
    int rx_stalls = 0;

    logic [7:0]  exp_tx[$];
    logic [7:0]  got_tx[$];
    logic [67:0] exp_wr[$];
    logic [67:0] got_wr[$];
    logic [8:0]  e9, g9;
    logic [68:0] e69, g69;

    always #5 clk = ~clk;

    dbg_mem_loader #(.RD_LAT(1), .TIMEOUT(16)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid && !sel),
        .rx_ready  (rx_ready_a),
        .tx_data   (tx_data_a),
        .tx_valid  (tx_valid_a),
        .tx_ready  (tx_ready && !sel),
        .web       (web_a),
        .addrb     (addrb_a),
        .dinb      (dinb_a),
        .doutb     (doutb_a),
        .o_busy    (busy_a),
        .o_timeout (tmo_a)
    );

    dbg_mem_loader #(.RD_LAT(3), .TIMEOUT(16)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid && sel),
        .rx_ready  (rx_ready_b),
        .tx_data   (tx_data_b),
        .tx_valid  (tx_valid_b),
        .tx_ready  (tx_ready && sel),
        .web       (web_b),
        .addrb     (addrb_b),
        .dinb      (dinb_b),
        .doutb     (doutb_b),
        .o_busy    (busy_b),
        .o_timeout (tmo_b)
    );

    assign rx_ready  = sel ? rx_ready_b : rx_ready_a;
    assign tx_valid  = sel ? tx_valid_b : tx_valid_a;
    assign tx_data   = sel ? tx_data_b  : tx_data_a;
    assign web       = sel ? web_b      : web_a;
    assign addrb     = sel ? addrb_b    : addrb_a;
    assign dinb      = sel ? dinb_b     : dinb_a;
    assign o_busy    = sel ? busy_b     : busy_a;
    assign o_timeout = sel ? tmo_b      : tmo_a;

    // Port-B memories: latency 1 for instance A, latency 3 for instance B.
    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];
    logic [31:0] rd_a;
    logic [31:0] pipe_b [3];

    always @(posedge clk) begin
        if (web_a == 4'hF) mem_a[addrb_a[5:0]] <= dinb_a;
        rd_a <= mem_a[addrb_a[5:0]];
        if (web_b == 4'hF) mem_b[addrb_b[5:0]] <= dinb_b;
        pipe_b[0] <= mem_b[addrb_b[5:0]];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign doutb_a = rd_a;
    assign doutb_b = pipe_b[2];

    // Monitor samples on the falling edge, midway between active edges.
    always @(negedge clk) begin
        if (tx_valid && tx_ready) got_tx.push_back(tx_data);
        if (web != 4'h0) got_wr.push_back({web, addrb, dinb});
    end

    // ------------------------------------------------------------------
    // Drivers (no checking; an RX stall is tallied for the calling test)
    // ------------------------------------------------------------------
    task automatic send_byte(input logic [7:0] b);
        bit done;
        done = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (rx_ready) done = 1'b1;
        end
        if (!done) rx_stalls++;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [15:0] n);
        send_byte(cmd);
        send_word(addr);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (!o_busy) ok = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (rx_ready_a !== 1'b0 || rx_ready_b !== 1'b0) begin
            miscompares++;
            $display("FAIL reset rx_ready: got %b/%b want 0/0", rx_ready_a, rx_ready_b);
        end
        vectors++;
        if ({web_a, web_b} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset web: got %h/%h want 0/0", web_a, web_b);
        end
        vectors++;
        if ({tx_valid_a, busy_a, tmo_a, tx_valid_b, busy_b, tmo_b} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset flags: got txv/busy/tmo %b%b%b %b%b%b want all 0",
                     tx_valid_a, busy_a, tmo_a, tx_valid_b, busy_b, tmo_b);
        end
        vectors++;
        if (addrb_a !== 32'h0 || dinb_a !== 32'h0 || tx_data_a !== 8'h00) begin
            miscompares++;
            $display("FAIL reset data: got addrb %h dinb %h tx_data %h want 0", addrb_a,
                     dinb_a, tx_data_a);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (rx_ready_a !== 1'b1 || rx_ready_b !== 1'b1) begin
            miscompares++;
            $display("FAIL idle rx_ready: got %b/%b want 1/1", rx_ready_a, rx_ready_b);
        end
        @(posedge clk);
        #1;
        got_tx.delete();
        got_wr.delete();
    endtask

    task automatic test_write(input logic s);
        bit ok;
        sel = s;
        exp_wr.push_back({4'hF, 32'd4, 32'h12345678});
        exp_wr.push_back({4'hF, 32'd5, 32'hDEADBEEF});
        exp_tx.push_back(8'h06);
        send_hdr(8'h57, 32'h0000_0010, 16'd2);
        send_word(32'h12345678);
        send_word(32'hDEADBEEF);
        wait_idle(ok);
        vectors++;
        if (!ok || rx_stalls != 0) begin
            miscompares++;
            $display("FAIL write%0d progress: got idle=%0d stalls=%0d want 1/0", s, ok, rx_stalls);
        end
        rx_stalls = 0;
        while (exp_tx.size() != 0 || got_tx.size() != 0) begin
            e9 = 9'h0; g9 = 9'h0;
            if (exp_tx.size() != 0) e9 = {1'b1, exp_tx.pop_front()};
            if (got_tx.size() != 0) g9 = {1'b1, got_tx.pop_front()};
            vectors++;
            if (g9 !== e9) begin
                miscompares++;
                $display("FAIL write%0d tx: got %h want %h", s, g9, e9);
            end
        end
        while (exp_wr.size() != 0 || got_wr.size() != 0) begin
            e69 = '0; g69 = '0;
            if (exp_wr.size() != 0) e69 = {1'b1, exp_wr.pop_front()};
            if (got_wr.size() != 0) g69 = {1'b1, got_wr.pop_front()};
            vectors++;
            if (g69 !== e69) begin
                miscompares++;
                $display("FAIL write%0d portb: got %h want %h", s, g69, e69);
            end
        end
    endtask

    task automatic test_read(input logic s);
        bit ok;
        logic [7:0] bytes [9];
        bytes = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h06};
        sel = s;
        foreach (bytes[i]) exp_tx.push_back(bytes[i]);
        send_hdr(8'h52, 32'h0000_0010, 16'd2);
        wait_idle(ok);
        vectors++;
        if (!ok || rx_stalls != 0) begin
            miscompares++;
            $display("FAIL read%0d progress: got idle=%0d stalls=%0d want 1/0", s, ok, rx_stalls);
        end
        rx_stalls = 0;
        while (exp_tx.size() != 0 || got_tx.size() != 0) begin
            e9 = 9'h0; g9 = 9'h0;
            if (exp_tx.size() != 0) e9 = {1'b1, exp_tx.pop_front()};
            if (got_tx.size() != 0) g9 = {1'b1, got_tx.pop_front()};
            vectors++;
            if (g9 !== e9) begin
                miscompares++;
                $display("FAIL read%0d tx: got %h want %h", s, g9, e9);
            end
        end
        vectors++;
        if (got_wr.size() != 0) begin
            miscompares++;
            $display("FAIL read%0d web: got %0d writes want 0", s, got_wr.size());
            got_wr.delete();
        end
    endtask

    task automatic test_misaligned();
        bit ok1, ok2;
        sel = 1'b0;
        exp_tx.push_back(8'h15);
        send_hdr(8'h57, 32'h0000_0012, 16'd1);
        send_word(32'h0BADF00D);
        wait_idle(ok1);
        exp_wr.push_back({4'hF, 32'd6, 32'hCAFEF00D});
        exp_tx.push_back(8'h06);
        send_hdr(8'h57, 32'h0000_0018, 16'd1);
        send_word(32'hCAFEF00D);
        wait_idle(ok2);
        vectors++;
        if (!ok1 || !ok2 || rx_stalls != 0) begin
            miscompares++;
            $display("FAIL misaligned progress: got idle=%0d%0d stalls=%0d want 11/0", ok1, ok2,
                     rx_stalls);
        end
        rx_stalls = 0;
        while (exp_tx.size() != 0 || got_tx.size() != 0) begin
            e9 = 9'h0; g9 = 9'h0;
            if (exp_tx.size() != 0) e9 = {1'b1, exp_tx.pop_front()};
            if (got_tx.size() != 0) g9 = {1'b1, got_tx.pop_front()};
            vectors++;
            if (g9 !== e9) begin
                miscompares++;
                $display("FAIL misaligned tx: got %h want %h", g9, e9);
            end
        end
        while (exp_wr.size() != 0 || got_wr.size() != 0) begin
            e69 = '0; g69 = '0;
            if (exp_wr.size() != 0) e69 = {1'b1, exp_wr.pop_front()};
            if (got_wr.size() != 0) g69 = {1'b1, got_wr.pop_front()};
            vectors++;
            if (g69 !== e69) begin
                miscompares++;
                $display("FAIL misaligned portb: got %h want %h", g69, e69);
            end
        end
    endtask

    task automatic test_bad_cmd();
        bit ok1, ok2, ok3;
        sel = 1'b0;
        exp_tx.push_back(8'h15);
        send_byte(8'h41);
        wait_idle(ok1);
        @(negedge clk);
        vectors++;
        if (rx_ready !== 1'b1 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_cmd idle: got rx_ready %b busy %b want 1 0", rx_ready, o_busy);
        end
        @(posedge clk);
        #1;
        exp_tx.push_back(8'h06);
        send_hdr(8'h57, 32'h0000_0040, 16'd0);
        wait_idle(ok2);
        exp_tx.push_back(8'h15);
        send_hdr(8'h52, 32'h0000_0041, 16'd3);
        wait_idle(ok3);
        vectors++;
        if (!ok1 || !ok2 || !ok3 || rx_stalls != 0) begin
            miscompares++;
            $display("FAIL bad_cmd progress: got idle=%0d%0d%0d stalls=%0d want 111/0", ok1, ok2,
                     ok3, rx_stalls);
        end
        rx_stalls = 0;
        while (exp_tx.size() != 0 || got_tx.size() != 0) begin
            e9 = 9'h0; g9 = 9'h0;
            if (exp_tx.size() != 0) e9 = {1'b1, exp_tx.pop_front()};
            if (got_tx.size() != 0) g9 = {1'b1, got_tx.pop_front()};
            vectors++;
            if (g9 !== e9) begin
                miscompares++;
                $display("FAIL bad_cmd tx: got %h want %h", g9, e9);
            end
        end
        vectors++;
        if (got_wr.size() != 0) begin
            miscompares++;
            $display("FAIL bad_cmd web: got %0d writes want 0", got_wr.size());
            got_wr.delete();
        end
    endtask

    task automatic test_timeout();
        int n;
        bit seen;
        sel = 1'b0;
        send_hdr(8'h57, 32'h0000_0000, 16'd1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        n = 0;
        seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (o_timeout) begin
                seen = 1'b1;
                n = i;
            end
        end
        vectors++;
        if (!seen || n < 15 || n > 17) begin
            miscompares++;
            $display("FAIL timeout delay: got seen=%0d after %0d cycles want 1 after ~16", seen, n);
        end
        @(negedge clk);
        vectors++;
        if (o_timeout !== 1'b0 || o_busy !== 1'b0 || rx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout after: got tmo %b busy %b rx_ready %b want 0 0 1", o_timeout,
                     o_busy, rx_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (got_tx.size() != 0 || got_wr.size() != 0 || rx_stalls != 0) begin
            miscompares++;
            $display("FAIL timeout side effects: got tx %0d wr %0d stalls %0d want 0 0 0",
                     got_tx.size(), got_wr.size(), rx_stalls);
            got_tx.delete();
            got_wr.delete();
        end
        rx_stalls = 0;
    endtask

    task automatic test_backpressure();
        bit ok, up;
        int bad;
        sel = 1'b0;
        tx_ready = 1'b0;
        send_hdr(8'h52, 32'h0000_0010, 16'd1);
        up = 1'b0;
        for (int i = 0; i < 50 && !up; i++) begin
            @(negedge clk);
            if (tx_valid) up = 1'b1;
        end
        bad = 0;
        rx_data = 8'h57;
        rx_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_data !== 8'h78 || tx_valid !== 1'b1 || rx_ready !== 1'b0) bad++;
        end
        vectors++;
        if (!up || bad != 0) begin
            miscompares++;
            $display("FAIL backpressure hold: got valid=%0d unstable cycles %0d want 1 0", up, bad);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        exp_tx.push_back(8'h78);
        exp_tx.push_back(8'h56);
        exp_tx.push_back(8'h34);
        exp_tx.push_back(8'h12);
        exp_tx.push_back(8'h06);
        wait_idle(ok);
        vectors++;
        if (!ok || rx_stalls != 0) begin
            miscompares++;
            $display("FAIL backpressure progress: got idle=%0d stalls=%0d want 1/0", ok, rx_stalls);
        end
        rx_stalls = 0;
        while (exp_tx.size() != 0 || got_tx.size() != 0) begin
            e9 = 9'h0; g9 = 9'h0;
            if (exp_tx.size() != 0) e9 = {1'b1, exp_tx.pop_front()};
            if (got_tx.size() != 0) g9 = {1'b1, got_tx.pop_front()};
            vectors++;
            if (g9 !== e9) begin
                miscompares++;
                $display("FAIL backpressure tx: got %h want %h", g9, e9);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        sel = 1'b0;
        // Reset in the middle of WDATA.
        send_hdr(8'h57, 32'h0000_0020, 16'd1);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (o_busy !== 1'b0 || web !== 4'h0 || tx_valid !== 1'b0 || rx_ready !== 1'b1 ||
            addrb !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid state: got busy %b web %h txv %b rx_ready %b addrb %h want 0 0 0 1 0",
                     o_busy, web, tx_valid, rx_ready, addrb);
        end
        @(posedge clk);
        #1;
        // Reset landing on the WRITE cycle must suppress the write.
        send_hdr(8'h57, 32'h0000_0024, 16'd1);
        send_word(32'h99999999);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (got_wr.size() != 0 || got_tx.size() != 0) begin
            miscompares++;
            $display("FAIL reset_mid suppress: got wr %0d tx %0d want 0 0", got_wr.size(),
                     got_tx.size());
            got_wr.delete();
            got_tx.delete();
        end
        exp_wr.push_back({4'hF, 32'd8, 32'h55667788});
        exp_tx.push_back(8'h06);
        send_hdr(8'h57, 32'h0000_0020, 16'd1);
        send_word(32'h55667788);
        wait_idle(ok);
        vectors++;
        if (!ok || rx_stalls != 0) begin
            miscompares++;
            $display("FAIL reset_mid progress: got idle=%0d stalls=%0d want 1/0", ok, rx_stalls);
        end
        rx_stalls = 0;
        while (exp_tx.size() != 0 || got_tx.size() != 0) begin
            e9 = 9'h0; g9 = 9'h0;
            if (exp_tx.size() != 0) e9 = {1'b1, exp_tx.pop_front()};
            if (got_tx.size() != 0) g9 = {1'b1, got_tx.pop_front()};
            vectors++;
            if (g9 !== e9) begin
                miscompares++;
                $display("FAIL reset_mid tx: got %h want %h", g9, e9);
            end
        end
        while (exp_wr.size() != 0 || got_wr.size() != 0) begin
            e69 = '0; g69 = '0;
            if (exp_wr.size() != 0) e69 = {1'b1, exp_wr.pop_front()};
            if (got_wr.size() != 0) g69 = {1'b1, got_wr.pop_front()};
            vectors++;
            if (g69 !== e69) begin
                miscompares++;
                $display("FAIL reset_mid portb: got %h want %h", g69, e69);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_write(1'b0);
        test_read(1'b0);
        test_write(1'b1);
        test_read(1'b1);
        test_misaligned();
        test_bad_cmd();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion want finish before 2ms");
        $fatal(1, "watchdog expired");
    end

endmodule
